// File: rtl/serial_accumulator.sv
// Bit-serial accumulator: WIDTH-bit A register, LSB-first serial add/sub/inc with
// optional ones'-complement end-around carry, plus single-cycle load/shift/clear.
module serial_accumulator #(
    parameter int WIDTH     = 16,
    parameter bit ONES_COMP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             carry_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc_out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_INC   = 3'd3;
    localparam logic [2:0] OP_SHL   = 3'd4;
    localparam logic [2:0] OP_SHR   = 3'd5;
    localparam logic [2:0] OP_CLEAR = 3'd6;
    localparam logic [2:0] OP_NOP   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        EAC  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             ready_q;

    logic             sum_bit;
    logic             maj;
    logic             last_bit;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] a_shl;
    logic [WIDTH-1:0] a_shr;

    // One full-adder slice; A rotates right so the sum bit lands in the MSB.
    assign sum_bit  = a_reg[0] ^ b_reg[0] ^ carry;
    assign maj      = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign a_next   = {sum_bit, a_reg[WIDTH-1:1]};
    assign a_shl    = {a_reg[WIDTH-2:0], 1'b0};
    assign a_shr    = {a_reg[WIDTH-1], a_reg[WIDTH-1:1]};

    assign ready = ready_q;
    assign busy  = ~ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            ready_q   <= 1'b1;
            done      <= 1'b0;
            acc_out   <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_LOAD: begin
                                a_reg   <= bus_in;
                                acc_out <= bus_in;
                                done    <= 1'b1;
                            end
                            OP_ADD, OP_SUB, OP_INC: begin
                                if (op == OP_ADD) begin
                                    b_reg <= bus_in;
                                    carry <= carry_in;
                                end else if (op == OP_SUB) begin
                                    b_reg <= ~bus_in;
                                    carry <= ~ONES_COMP;
                                end else begin
                                    b_reg <= '0;
                                    carry <= 1'b1;
                                end
                                cnt     <= '0;
                                state   <= ADD;
                                ready_q <= 1'b0;
                            end
                            OP_SHL: begin
                                a_reg   <= a_shl;
                                acc_out <= a_shl;
                                done    <= 1'b1;
                            end
                            OP_SHR: begin
                                a_reg   <= a_shr;
                                acc_out <= a_shr;
                                done    <= 1'b1;
                            end
                            OP_CLEAR: begin
                                a_reg   <= '0;
                                acc_out <= '0;
                                done    <= 1'b1;
                            end
                            default: begin
                                done <= 1'b1;
                            end
                        endcase
                    end
                end

                ADD: begin
                    a_reg <= a_next;
                    b_reg <= b_reg >> 1;
                    carry <= maj;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        carry_out <= maj;
                        overflow  <= carry ^ maj;
                        cnt       <= '0;
                        // A carry out of the MSB in ones'-complement wraps around as +1.
                        if (ONES_COMP && maj) begin
                            state <= EAC;
                            b_reg <= '0;
                            carry <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                            acc_out <= a_next;
                            done    <= 1'b1;
                        end
                    end
                end

                EAC: begin
                    a_reg <= a_next;
                    b_reg <= b_reg >> 1;
                    carry <= maj;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        cnt     <= '0;
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        acc_out <= a_next;
                        done    <= 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_accumulator.sv
// Directed bench for serial_accumulator: one ones'-complement and one two's-complement
// instance, each driven by its own command stream and checked against hand-worked values.
module tb_serial_accumulator;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_INC   = 3'd3;
    localparam logic [2:0] OP_SHL   = 3'd4;
    localparam logic [2:0] OP_SHR   = 3'd5;
    localparam logic [2:0] OP_CLEAR = 3'd6;

    localparam bit OC = 1'b0;
    localparam bit TC = 1'b1;

    logic        clk;
    logic        rst;

    logic        oc_start, oc_cin, oc_ready, oc_busy, oc_done, oc_carry, oc_ovf;
    logic [2:0]  oc_op;
    logic [15:0] oc_bus, oc_acc;

    logic        tc_start, tc_cin, tc_ready, tc_busy, tc_done, tc_carry, tc_ovf;
    logic [2:0]  tc_op;
    logic [15:0] tc_bus, tc_acc;

    int vectors;
    int miscompares;

    serial_accumulator #(.WIDTH(16), .ONES_COMP(1'b1)) u_oc (
        .clk(clk), .rst(rst), .start(oc_start), .op(oc_op), .bus_in(oc_bus),
        .carry_in(oc_cin), .ready(oc_ready), .busy(oc_busy), .done(oc_done),
        .acc_out(oc_acc), .carry_out(oc_carry), .overflow(oc_ovf)
    );

    serial_accumulator #(.WIDTH(16), .ONES_COMP(1'b0)) u_tc (
        .clk(clk), .rst(rst), .start(tc_start), .op(tc_op), .bus_in(tc_bus),
        .carry_in(tc_cin), .ready(tc_ready), .busy(tc_busy), .done(tc_done),
        .acc_out(tc_acc), .carry_out(tc_carry), .overflow(tc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        vectors++;
        if (got !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
        end
    endtask

    function automatic logic getDone(input bit sel);
        return sel ? tc_done : oc_done;
    endfunction

    function automatic logic [15:0] getAcc(input bit sel);
        return sel ? tc_acc : oc_acc;
    endfunction

    task automatic issueCmd(input bit sel, input logic [2:0] op, input logic [15:0] val, input logic cin);
        @(negedge clk);
        if (sel) begin
            tc_op = op; tc_bus = val; tc_cin = cin; tc_start = 1'b1;
        end else begin
            oc_op = op; oc_bus = val; oc_cin = cin; oc_start = 1'b1;
        end
        @(posedge clk);
        #1;
        oc_start = 1'b0;
        tc_start = 1'b0;
    endtask

    // Returns n where done was first seen in the n-th cycle from the current point, or -1.
    task automatic waitDone(input bit sel, output int lat);
        lat = -1;
        for (int n = 1; n <= 80 && lat < 0; n++) begin
            @(negedge clk);
            if (getDone(sel) === 1'b1) lat = n;
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic [2:0] op, input logic [15:0] val,
                                 input logic cin, output int lat);
        issueCmd(sel, op, val, cin);
        waitDone(sel, lat);
    endtask

    int lat;
    int done_seen;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        oc_start = 1'b0; oc_op = 3'd7; oc_bus = '0; oc_cin = 1'b0;
        tc_start = 1'b0; tc_op = 3'd7; tc_bus = '0; tc_cin = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_acc",   {16'd0, oc_acc}, 32'h0);
        checkOutput("rst_ready", {31'd0, oc_ready}, 32'h1);
        checkOutput("rst_busy",  {31'd0, oc_busy}, 32'h0);
        checkOutput("rst_done",  {31'd0, oc_done}, 32'h0);
        checkOutput("rst_cout",  {31'd0, oc_carry}, 32'h0);
        checkOutput("rst_ovf",   {31'd0, oc_ovf}, 32'h0);

        $display("[TB] ones-complement add without end-around carry");
        applyStimulus(OC, OP_LOAD, 16'h0005, 1'b0, lat);
        checkOutput("load_lat", lat, 1);
        checkOutput("load_acc", {16'd0, oc_acc}, 32'h0005);
        @(negedge clk);
        checkOutput("load_done_drop", {31'd0, oc_done}, 32'h0);
        issueCmd(OC, OP_ADD, 16'h0003, 1'b0);
        @(negedge clk);
        checkOutput("add_busy",  {31'd0, oc_busy}, 32'h1);
        checkOutput("add_ready", {31'd0, oc_ready}, 32'h0);
        checkOutput("add_acc_hold", {16'd0, oc_acc}, 32'h0005);
        waitDone(OC, lat);
        checkOutput("add_lat", lat + 1, 17);
        checkOutput("add_acc", {16'd0, oc_acc}, 32'h0008);
        checkOutput("add_cout", {31'd0, oc_carry}, 32'h0);
        checkOutput("add_ovf",  {31'd0, oc_ovf}, 32'h0);
        checkOutput("add_ready_done", {31'd0, oc_ready}, 32'h1);

        $display("[TB] ones-complement end-around carry");
        applyStimulus(OC, OP_LOAD, 16'hFFFE, 1'b0, lat);
        applyStimulus(OC, OP_ADD, 16'h0003, 1'b0, lat);
        checkOutput("eac_lat", lat, 33);
        checkOutput("eac_acc", {16'd0, oc_acc}, 32'h0002);
        checkOutput("eac_cout", {31'd0, oc_carry}, 32'h1);
        checkOutput("eac_ovf", {31'd0, oc_ovf}, 32'h0);
        applyStimulus(OC, OP_LOAD, 16'hFFFF, 1'b0, lat);
        checkOutput("load_keeps_cout", {31'd0, oc_carry}, 32'h1);
        applyStimulus(OC, OP_INC, 16'h0000, 1'b0, lat);
        checkOutput("inc_lat", lat, 33);
        checkOutput("inc_acc", {16'd0, oc_acc}, 32'h0001);
        applyStimulus(OC, OP_LOAD, 16'h0005, 1'b0, lat);
        applyStimulus(OC, OP_SUB, 16'h0003, 1'b0, lat);
        checkOutput("oc_sub_acc", {16'd0, oc_acc}, 32'h0002);
        applyStimulus(OC, OP_LOAD, 16'h0001, 1'b0, lat);
        applyStimulus(OC, OP_ADD, 16'h0001, 1'b1, lat);
        checkOutput("oc_addc_acc", {16'd0, oc_acc}, 32'h0003);
        checkOutput("oc_addc_lat", lat, 17);

        $display("[TB] two's-complement add/sub");
        applyStimulus(TC, OP_LOAD, 16'h7FFF, 1'b0, lat);
        applyStimulus(TC, OP_ADD, 16'h0001, 1'b0, lat);
        checkOutput("tc_add_lat", lat, 17);
        checkOutput("tc_add_acc", {16'd0, tc_acc}, 32'h8000);
        checkOutput("tc_add_ovf", {31'd0, tc_ovf}, 32'h1);
        checkOutput("tc_add_cout", {31'd0, tc_carry}, 32'h0);
        applyStimulus(TC, OP_LOAD, 16'hFFFF, 1'b0, lat);
        applyStimulus(TC, OP_INC, 16'h0000, 1'b0, lat);
        checkOutput("tc_inc_lat", lat, 17);
        checkOutput("tc_inc_acc", {16'd0, tc_acc}, 32'h0000);
        checkOutput("tc_inc_cout", {31'd0, tc_carry}, 32'h1);

        // Mid-stream reset while the two's-complement unit is busy.
        applyStimulus(TC, OP_LOAD, 16'h7FFF, 1'b0, lat);
        applyStimulus(TC, OP_ADD, 16'h0001, 1'b0, lat);
        issueCmd(TC, OP_ADD, 16'h2222, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("mrst_acc",   {16'd0, tc_acc}, 32'h0);
        checkOutput("mrst_ready", {31'd0, tc_ready}, 32'h1);
        checkOutput("mrst_busy",  {31'd0, tc_busy}, 32'h0);
        checkOutput("mrst_ovf",   {31'd0, tc_ovf}, 32'h0);
        checkOutput("mrst_cout",  {31'd0, tc_carry}, 32'h0);

        applyStimulus(TC, OP_LOAD, 16'h0005, 1'b0, lat);
        applyStimulus(TC, OP_SUB, 16'h8007, 1'b0, lat);
        checkOutput("tc_sub_acc", {16'd0, tc_acc}, 32'h7FFE);
        checkOutput("tc_sub_ovf", {31'd0, tc_ovf}, 32'h0);
        checkOutput("tc_sub_cout", {31'd0, tc_carry}, 32'h0);

        $display("[TB] shifts, clear, ignored start");
        applyStimulus(OC, OP_LOAD, 16'h8004, 1'b0, lat);
        applyStimulus(OC, OP_SHR, 16'h0000, 1'b0, lat);
        checkOutput("shr_lat", lat, 1);
        checkOutput("shr_acc", {16'd0, oc_acc}, 32'hC002);
        applyStimulus(OC, OP_SHL, 16'h0000, 1'b0, lat);
        checkOutput("shl_acc", {16'd0, oc_acc}, 32'h8004);
        applyStimulus(OC, OP_CLEAR, 16'h0000, 1'b0, lat);
        checkOutput("clr_acc", {16'd0, oc_acc}, 32'h0000);
        applyStimulus(OC, OP_LOAD, 16'h0010, 1'b0, lat);
        issueCmd(OC, OP_ADD, 16'h0021, 1'b0);
        @(negedge clk);
        oc_op = OP_LOAD; oc_bus = 16'hFFFF; oc_start = 1'b1;
        @(negedge clk);
        oc_start = 1'b0;
        waitDone(OC, lat);
        checkOutput("ign_lat", lat + 2, 17);
        checkOutput("ign_acc", {16'd0, oc_acc}, 32'h0031);

        $display("[TB] reset during serial op");
        issueCmd(OC, OP_ADD, 16'h0001, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_acc",   {16'd0, getAcc(OC)}, 32'h0);
        checkOutput("abort_ready", {31'd0, oc_ready}, 32'h1);
        checkOutput("abort_done",  {31'd0, oc_done}, 32'h0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (oc_done === 1'b1) done_seen++;
        end
        checkOutput("abort_no_done", done_seen, 0);
        applyStimulus(OC, OP_LOAD, 16'h1234, 1'b0, lat);
        checkOutput("post_abort_lat", lat, 1);
        checkOutput("post_abort_acc", {16'd0, oc_acc}, 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_accumulator.md
Name: serial_accumulator

Overview:
- Parametrised bit-serial accumulator: generalised successor of the fixed single-bit accumulator slice used in the ALU datapath.
- Holds a WIDTH-bit A register and executes load, add, subtract, increment, shift and clear commands under a start/ready/done handshake.
- Arithmetic is processed one bit per clock, LSB first.
- ONES_COMP selects Apollo-style ones'-complement arithmetic with a serial end-around-carry pass, or plain two's-complement arithmetic.

Parameters:
WIDTH, 16, datapath width in bits (>=4)
ONES_COMP, 1, 1 = ones'-complement with end-around carry; 0 = two's complement

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  command request; accepted only when ready=1
op  input  3  command: 0 LOAD, 1 ADD, 2 SUB, 3 INC, 4 SHL, 5 SHR, 6 CLEAR, 7 NOP
bus_in  input  WIDTH  operand, sampled on the accept edge
carry_in  input  1  extra carry for ADD only, sampled on the accept edge
ready  output  1  idle, can accept a command
busy  output  1  serial operation in progress (equals ~ready)
done  output  1  one-cycle completion pulse
acc_out  output  WIDTH  committed A value
carry_out  output  1  raw carry out of the MSB from the main pass of the last arithmetic op
overflow  output  1  signed overflow of the last arithmetic op

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE; A, acc_out, operand shift register, bit counter, carry_out, overflow, done all 0; ready=1, busy=0. Reset aborts any operation in flight; A is not partially updated.
- States: IDLE, ADD, EAC.
- Accept: an edge with start=1 and ready=1. start while busy is ignored, with no queuing.
- Single-cycle ops (LOAD, SHL, SHR, CLEAR, NOP), applied on the accept edge; state stays IDLE:
  - LOAD: A <= bus_in.
  - SHL: A <= {A[WIDTH-2:0], 0}.
  - SHR: arithmetic, A <= {A[MSB], A[WIDTH-1:1]}.
  - CLEAR: A <= 0.
  - NOP: A unchanged.
  - acc_out is updated on the same edge. done=1 in the following cycle; carry_out and overflow unchanged.
- Serial ops (ADD, SUB, INC):
  - On accept, latch operand B: ADD -> bus_in; SUB -> ~bus_in; INC -> 0.
  - Initial carry c0: ADD -> carry_in; SUB -> (ONES_COMP ? 0 : 1); INC -> 1.
  - Enter ADD with counter=0.
  - ADD state: each cycle sum = A[0]^B[0]^c, A <= {sum, A[WIDTH-1:1]}, B shifts right, c <= majority; runs exactly WIDTH cycles.
  - On the final bit: carry_out <= final carry; overflow <= carry into MSB XOR carry out of MSB.
  - If ONES_COMP=1 and final carry=1: enter EAC, a second WIDTH-cycle serial pass adding 1 (B=0, c0=1); carries out of this pass are discarded and do not change carry_out or overflow.
  - Otherwise return to IDLE.
  - On return to IDLE: acc_out <= A and done pulses high for the next cycle.
  - -0 (all ones) is not normalised.
- Latency, with accept at edge 0:
  - Single-cycle op: done in cycle 1.
  - Serial op without EAC: done in cycle WIDTH+1.
  - Serial op with EAC: done in cycle 2*WIDTH+1.
- In the done cycle ready=1, so back-to-back commands are allowed.
- acc_out, carry_out and overflow hold until the next completion. Intermediate A is never visible on acc_out.
- done is never high for more than one consecutive cycle unless commands are issued back-to-back.

Test Plan:
1. Assert rst for 2 cycles, including mid-stream -> acc_out=0, ready=1, busy=0, done=0, carry_out=0, overflow=0.
2. WIDTH=16, ONES_COMP=1: LOAD 0x0005, then ADD bus_in=0x0003, carry_in=0 -> busy for 16 cycles, done in cycle 17 after accept, acc_out=0x0008, carry_out=0, overflow=0.
3. ONES_COMP=1: LOAD 0xFFFE (-1), ADD 0x0003 -> main pass gives 0x0001 with carry 1, EAC pass follows, done in cycle 33, acc_out=0x0002, carry_out=1; separately, INC on 0xFFFF -> acc_out=0x0001.
4. ONES_COMP=0: LOAD 0x7FFF, ADD 0x0001 -> acc_out=0x8000, overflow=1, carry_out=0, done in cycle 17; then SUB 0x8007 from LOAD 0x0005 -> acc_out=0x7FFE, overflow=0, carry_out=0.
5. Shifts: LOAD 0x8004, SHR -> 0xC002, done 1 cycle after accept; SHL -> 0x8004; CLEAR -> 0x0000; start pulsed during an ADD is ignored and the ADD result is unaffected.
6. Reset at cycle 8 of an ADD -> acc_out=0, ready=1 on the next cycle, no done pulse; a new LOAD 0x1234 is accepted immediately -> acc_out=0x1234.
